// File: rtl/gh_uart_pkg.sv
// Shared helpers for the UART core building blocks.
// - gh_width_t : unsigned integer type used for width arithmetic
// - gh_clog2   : ceiling log2, returns 0 for n <= 1
// - gh_fill_w  : width of a 0..depth occupancy counter (at least 1 bit)
package gh_uart_pkg;

    typedef int unsigned gh_width_t;

    function automatic gh_width_t gh_clog2(input gh_width_t n);
        gh_width_t r;
        gh_width_t v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic gh_width_t gh_fill_w(input gh_width_t depth);
        gh_width_t w;
        w = gh_clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gh_pipe_stage.sv
// Single clock-enabled register stage.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high, loads RST_VAL
//   clr  - synchronous clear, loads RST_VAL, wins over ce
//   ce   - clock enable, loads d
//   d    - next value
//   q    - registered value
module gh_pipe_stage #(
    parameter int              W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/gh_delay_line_ce.sv
// Multi-stage clock-enabled delay line with per-stage valid tracking.
// Each stage holds {data, valid}; an enabled edge shifts the whole line by
// one stage, clr flushes every stage back to RST_VAL/invalid.
// Ports:
//   clk, rst        - clock (rising edge), async active-high reset
//   ce, clr         - advance enable, synchronous flush (clr wins)
//   d, d_vld        - data/valid into stage 0
//   tap_sel         - stage index for tap_q/tap_vld (out of range -> RST_VAL/0)
//   q, q_vld        - registered last stage
//   tap_q, tap_vld  - selected stage
//   fill            - number of valid stages, 0..DEPTH
//   full, empty     - decode of fill
module gh_delay_line_ce
    import gh_uart_pkg::*;
#(
    parameter int                WIDTH   = 8,
    parameter int                DEPTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic                          clr,
    input  logic [WIDTH-1:0]              d,
    input  logic                          d_vld,
    input  logic [gh_clog2(DEPTH):0]      tap_sel,
    output logic [WIDTH-1:0]              q,
    output logic                          q_vld,
    output logic [WIDTH-1:0]              tap_q,
    output logic                          tap_vld,
    output logic [gh_fill_w(DEPTH)-1:0]   fill,
    output logic                          full,
    output logic                          empty
);

    localparam int TW = gh_clog2(DEPTH) + 1;
    localparam int FW = gh_fill_w(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("gh_delay_line_ce: DEPTH must be at least 1");
    end

    // Stage layout: {data, valid}; the valid bit resets to 0.
    logic [WIDTH:0] stg [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH:0] stg_d;
        if (i == 0) begin : g_first
            assign stg_d = {d, d_vld};
        end else begin : g_next
            assign stg_d = stg[i-1];
        end

        gh_pipe_stage #(
            .W       (WIDTH + 1),
            .RST_VAL ({RST_VAL, 1'b0})
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .ce  (ce),
            .d   (stg_d),
            .q   (stg[i])
        );
    end

    assign q     = stg[DEPTH-1][WIDTH:1];
    assign q_vld = stg[DEPTH-1][0];

    // Entry and exit on the same edge cancel; the valid bits bound the
    // count to 0..DEPTH so the modular arithmetic never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else if (clr) begin
            fill <= '0;
        end else if (ce) begin
            fill <= fill + FW'(d_vld) - FW'(stg[DEPTH-1][0]);
        end
    end

    assign full  = (fill == FW'(DEPTH));
    assign empty = (fill == '0);

    always_comb begin
        tap_q   = RST_VAL;
        tap_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_q   = stg[i][WIDTH:1];
                tap_vld = stg[i][0];
            end
        end
    end

endmodule

// File: tb/tb_gh_delay_line_ce.sv
// Directed bench for gh_delay_line_ce: a DEPTH=4 instance and a DEPTH=1
// instance share the stimulus.
module tb_gh_delay_line_ce;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       clr;
    logic [7:0] d;
    logic       d_vld;
    logic [2:0] tap_sel;
    logic [0:0] tap_sel1;

    logic [7:0] q, tap_q;
    logic       q_vld, tap_vld, full, empty;
    logic [2:0] fill;

    logic [7:0] q1, tap_q1;
    logic       q_vld1, tap_vld1, full1, empty1;
    logic [0:0] fill1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gh_delay_line_ce #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) dut4 (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr), .d(d), .d_vld(d_vld),
        .tap_sel(tap_sel), .q(q), .q_vld(q_vld), .tap_q(tap_q), .tap_vld(tap_vld),
        .fill(fill), .full(full), .empty(empty)
    );

    gh_delay_line_ce #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr), .d(d), .d_vld(d_vld),
        .tap_sel(tap_sel1), .q(q1), .q_vld(q_vld1), .tap_q(tap_q1), .tap_vld(tap_vld1),
        .fill(fill1), .full(full1), .empty(empty1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; clr = 1'b0; d = '0; d_vld = 1'b0;
        tap_sel = '0; tap_sel1 = '0;
        #12;
        chk("rst_q",      32'(q), 'hA5);
        chk("rst_q_vld",  32'(q_vld), 0);
        chk("rst_fill",   32'(fill), 0);
        chk("rst_empty",  32'(empty), 1);
        chk("rst_full",   32'(full), 0);
        chk("rst_q1",     32'(q1), 'h3C);
        chk("rst_tap_vld",32'(tap_vld), 0);
        rst = 1'b0;

        // Latency: push 01..04 every cycle
        ce = 1'b1; d_vld = 1'b1;
        d = 8'h01; step();
        chk("lat_fill1", 32'(fill), 1);
        chk("lat_qvld1", 32'(q_vld), 0);
        chk("d1_q",      32'(q1), 'h01);
        chk("d1_qvld",   32'(q_vld1), 1);
        chk("d1_full",   32'(full1), 1);
        chk("d1_tap",    32'(tap_q1), 'h01);
        d = 8'h02; step();
        chk("lat_fill2", 32'(fill), 2);
        chk("d1_q2",     32'(q1), 'h02);
        d = 8'h03; step();
        chk("lat_fill3", 32'(fill), 3);
        chk("lat_full3", 32'(full), 0);
        d = 8'h04; step();
        chk("lat_fill4", 32'(fill), 4);
        chk("lat_q",     32'(q), 'h01);
        chk("lat_qvld",  32'(q_vld), 1);
        chk("lat_full",  32'(full), 1);

        // Tap range: stages are 04,03,02,01
        tap_sel = 3'd2; #1;
        chk("tap2_q",   32'(tap_q), 'h02);
        chk("tap2_vld", 32'(tap_vld), 1);
        tap_sel = 3'd5; #1;
        chk("tap5_q",   32'(tap_q), 'hA5);
        chk("tap5_vld", 32'(tap_vld), 0);
        tap_sel = 3'd0;

        // Steady state and bubble
        d = 8'h05; step();
        chk("ss_fill", 32'(fill), 4);
        chk("ss_q",    32'(q), 'h02);
        d = 8'hFF; d_vld = 1'b0; step();
        chk("bub_fill",   32'(fill), 3);
        chk("bub_tap_q",  32'(tap_q), 'hFF);
        chk("bub_tap_vld",32'(tap_vld), 0);
        chk("bub_q",      32'(q), 'h03);
        chk("d1_bub_q",   32'(q1), 'hFF);
        chk("d1_bub_vld", 32'(q_vld1), 0);
        chk("d1_empty",   32'(empty1), 1);

        // Refill with four valid entries
        d_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'h21 + 8'(i);
            step();
        end
        chk("refill_fill", 32'(fill), 4);
        chk("refill_q",    32'(q), 'h21);

        // Flush beats a simultaneous enabled push
        clr = 1'b1; d = 8'h55; d_vld = 1'b1; step();
        clr = 1'b0;
        chk("fl_q",       32'(q), 'hA5);
        chk("fl_qvld",    32'(q_vld), 0);
        chk("fl_fill",    32'(fill), 0);
        chk("fl_empty",   32'(empty), 1);
        chk("fl_tap_q",   32'(tap_q), 'hA5);
        chk("fl_tap_vld", 32'(tap_vld), 0);
        chk("fl_q1",      32'(q1), 'h3C);
        d = 8'h00; d_vld = 1'b0;
        step(); chk("fl_after1", 32'(q), 'hA5);
        step(); chk("fl_after2", 32'(q), 'hA5);
        step(); chk("fl_after3", 32'(q), 'hA5);
        step(); chk("fl_after4", 32'(q), 'h00);
        chk("fl_fill_after", 32'(fill), 0);

        // Gated enable: 11 reaches q after four enabled edges
        d = 8'h11; d_vld = 1'b1; ce = 1'b1; step();
        chk("ge_fill", 32'(fill), 1);
        chk("ge_tap",  32'(tap_q), 'h11);
        d = 8'h00; d_vld = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            ce = 1'b0; step();
            chk("ge_hold_q",    32'(q), 'h00);
            chk("ge_hold_fill", 32'(fill), 1);
            chk("ge_hold_tvld", 32'(tap_vld), (k == 2) ? 1 : 0);
            ce = 1'b1; step();
            chk("ge_qvld", 32'(q_vld), (k == 4) ? 1 : 0);
        end
        chk("ge_q", 32'(q), 'h11);
        ce = 1'b0; step();
        chk("ge_q_hold", 32'(q), 'h11);
        chk("ge_qvld_hold", 32'(q_vld), 1);

        // Async reset with a full line
        ce = 1'b1; d_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'h31 + 8'(i);
            step();
        end
        chk("pre_rst_full", 32'(full), 1);
        rst = 1'b1; #2;
        chk("arst_q",     32'(q), 'hA5);
        chk("arst_qvld",  32'(q_vld), 0);
        chk("arst_fill",  32'(fill), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_q1",    32'(q1), 'h3C);
        #1 rst = 1'b0;
        d = 8'h77; step();
        chk("post_rst_tap",  32'(tap_q), 'h77);
        chk("post_rst_tvld", 32'(tap_vld), 1);
        chk("post_rst_fill", 32'(fill), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
